// File: rtl/mod_adder_pipe.sv
// Pipelined modular adder: (A + B) mod (2^WIDTH - K) on a valid/ready stream.
// Two Sklansky prefix trees run side by side: one for A+B, one for the enveloped A+B+K.
module mod_adder_pipe #(
  parameter int WIDTH     = 7,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4,
  parameter int K_RESET   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_k,
  output logic [WIDTH-1:0] k_q,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int L = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] K_INIT = WIDTH'(K_RESET);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] gq;
    logic [WIDTH-1:0] pq;
    logic [WIDTH-1:0] hq;
    logic             bq_top;
  } beat_t;

  logic             adv;
  logic [WIDTH-1:0] k_reg;
  logic [WIDTH-1:0] mod_m;
  logic [WIDTH-1:0] a_env;
  logic [WIDTH-1:0] b_env;
  logic [WIDTH-1:0] b_env_sh;
  beat_t            s1_next;
  beat_t            s1_q;
  beat_t            last;
  logic [L-1:0]     lvl_valid;
  logic             carry_sel;
  logic [WIDTH-1:0] sum_next;
  logic             unused_prop;

  // A single global enable: the whole pipe holds whenever the output is stalled.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign k_q      = k_reg;
  assign mod_m    = '0 - k_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg <= K_INIT;
    end else if (cfg_we) begin
      k_reg <= cfg_k;
    end
  end

  // Carry-save compression of A + B + K into a' + 2*b'.
  assign a_env    = in_a ^ in_b ^ k_reg;
  assign b_env    = (in_a & in_b) | (k_reg & (in_a ^ in_b));
  assign b_env_sh = {b_env[WIDTH-2:0], 1'b0};

  always_comb begin
    s1_next        = '0;
    s1_next.valid  = in_valid;
    s1_next.err    = (in_a >= mod_m) || (in_b >= mod_m);
    s1_next.tag    = in_tag;
    s1_next.g      = in_a & in_b;
    s1_next.p      = in_a | in_b;
    s1_next.h      = in_a ^ in_b;
    s1_next.gq     = a_env & b_env_sh;
    s1_next.pq     = a_env | b_env_sh;
    s1_next.hq     = a_env ^ b_env_sh;
    s1_next.bq_top = b_env[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else if (adv) begin
      s1_q <= s1_next;
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_level
    localparam bit REG_HERE = (((l + 1) % REG_EVERY) == 0) || (l == L - 1);
    beat_t stage_in;
    beat_t stage_out;
    beat_t comb_out;

    if (l == 0) begin : g_first
      assign stage_in = s1_q;
    end else begin : g_next
      assign stage_in = g_level[l-1].stage_out;
    end

    // Sklansky level: bit i merges with the top bit of the block just below it.
    always_comb begin
      comb_out = stage_in;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          comb_out.g[i]  = stage_in.g[i]  | (stage_in.g[((i >> l) << l) - 1]  & stage_in.p[i]);
          comb_out.p[i]  = stage_in.p[i]  &  stage_in.p[((i >> l) << l) - 1];
          comb_out.gq[i] = stage_in.gq[i] | (stage_in.gq[((i >> l) << l) - 1] & stage_in.pq[i]);
          comb_out.pq[i] = stage_in.pq[i] &  stage_in.pq[((i >> l) << l) - 1];
        end
      end
    end

    if (REG_HERE) begin : g_reg
      beat_t q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          q <= comb_out;
        end
      end
      assign stage_out = q;
    end else begin : g_pass
      assign stage_out = comb_out;
    end

    assign lvl_valid[l] = stage_out.valid;
  end

  assign last = g_level[L-1].stage_out;

  // Take the A+B+K result whenever either sum overflows 2^WIDTH.
  assign carry_sel = last.g[WIDTH-1] | last.gq[WIDTH-1] | last.bq_top;
  assign sum_next  = carry_sel ? (last.hq ^ {last.gq[WIDTH-2:0], 1'b0})
                               : (last.h  ^ {last.g[WIDTH-2:0], 1'b0});
  assign unused_prop = ^{last.p, last.pq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= last.valid;
      out_sum   <= sum_next;
      out_err   <= last.err;
      out_tag   <= last.tag;
    end
  end

  assign busy = s1_q.valid | (|lvl_valid) | out_valid;

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Directed + random scoreboard bench for mod_adder_pipe (WIDTH=7, K reset 20).
module tb_mod_adder_pipe;

  localparam int WIDTH = 7;
  localparam int TAG_W = 4;
  localparam int LAT   = 5;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_k;
  logic [WIDTH-1:0] k_q;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  typedef struct {
    int sum;
    int err;
    int tag;
    bit chk_sum;
    bit chk_lat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  int   cycle;
  int   k_model;
  bit   monitor_on;
  bit   check_lat;
  bit   random_ready;

  mod_adder_pipe #(
    .WIDTH(WIDTH), .REG_EVERY(1), .TAG_W(TAG_W), .K_RESET(20)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_k(cfg_k), .k_q(k_q),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err), .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one beat, waits for acceptance and records the expected result.
  task automatic applyStimulus(input int a, input int b, input int tag,
                               input bit use_exp, input int exp_sum, input int exp_err);
    exp_t e;
    bit   ok;
    int   m;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(b);
    in_tag   = TAG_W'(tag);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept", 32'(ok), 1);
    m         = (1 << WIDTH) - k_model;
    e.err     = (a >= m || b >= m) ? 1 : 0;
    e.sum     = (a + b) % m;
    if (use_exp) begin
      e.sum = exp_sum;
      e.err = exp_err;
    end
    e.tag     = tag;
    e.chk_sum = (e.err == 0);
    e.chk_lat = check_lat;
    e.cyc     = cycle;
    if (ok) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pops, stall stability and in_ready rule.
  initial begin
    exp_t             e;
    bit               hold_prev;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_err;
    logic [TAG_W-1:0] prev_tag;
    hold_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !monitor_on) begin
        hold_prev = 1'b0;
      end else begin
        checkOutput("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (hold_prev) begin
          checkOutput("stall_valid", 32'(out_valid), 1);
          checkOutput("stall_sum", 32'(out_sum), 32'(prev_sum));
          checkOutput("stall_err", 32'(out_err), 32'(prev_err));
          checkOutput("stall_tag", 32'(out_tag), 32'(prev_tag));
        end
        if (out_valid && out_ready) begin
          checkOutput("sb_nonempty", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("tag", 32'(out_tag), e.tag);
            checkOutput("err", 32'(out_err), e.err);
            if (e.chk_sum) checkOutput("sum", 32'(out_sum), e.sum);
            if (e.chk_lat) checkOutput("latency", cycle - e.cyc, LAT);
          end
        end
        hold_prev = out_valid && !out_ready;
        prev_sum  = out_sum;
        prev_err  = out_err;
        prev_tag  = out_tag;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (random_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    int m;
    rst          = 1'b1;
    cfg_we       = 1'b0;
    cfg_k        = '0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_tag       = '0;
    out_ready    = 1'b1;
    k_model      = 20;
    monitor_on   = 1'b0;
    check_lat    = 1'b0;
    random_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_sum", 32'(out_sum), 0);
    checkOutput("rst_out_err", 32'(out_err), 0);
    checkOutput("rst_out_tag", 32'(out_tag), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_k_q", 32'(k_q), 20);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    monitor_on = 1'b1;

    $display("[TB] directed sums with latency");
    check_lat = 1'b1;
    applyStimulus(69, 45, 1, 1'b1, 6, 0);
    drain();
    applyStimulus(10, 20, 2, 1'b1, 30, 0);
    drain();
    applyStimulus(107, 107, 3, 1'b1, 106, 0);
    drain();
    check_lat = 1'b0;

    $display("[TB] out-of-range operand");
    applyStimulus(110, 3, 9, 1'b1, 0, 1);
    applyStimulus(5, 6, 10, 1'b1, 11, 0);
    drain();

    $display("[TB] back-to-back stream");
    check_lat = 1'b1;
    m = (1 << WIDTH) - k_model;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(int'($urandom_range(0, m - 1)), int'($urandom_range(0, m - 1)), i, 1'b0, 0, 0);
    end
    drain();
    check_lat = 1'b0;

    $display("[TB] random backpressure");
    random_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(int'($urandom_range(0, m - 1)), int'($urandom_range(0, m - 1)), i % 16, 1'b0, 0, 0);
    end
    drain();
    random_ready = 1'b0;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] K reconfiguration");
    cfg_k  = 7'd28;
    cfg_we = 1'b1;
    applyStimulus(60, 50, 1, 1'b1, 2, 0);
    cfg_we  = 1'b0;
    k_model = 28;
    checkOutput("cfg_k_q", 32'(k_q), 28);
    applyStimulus(60, 50, 2, 1'b1, 10, 0);
    drain();

    $display("[TB] reset with beats in flight");
    applyStimulus(1, 2, 4, 1'b0, 0, 0);
    applyStimulus(3, 4, 5, 1'b0, 0, 0);
    applyStimulus(5, 6, 6, 1'b0, 0, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_k_q", 32'(k_q), 20);
    sb.delete();
    k_model = 20;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_rst_in_ready", 32'(in_ready), 1);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("stale_results", seen, 0);
    @(posedge clk);
    #1;
    applyStimulus(10, 20, 7, 1'b1, 30, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_adder_pipe.md
# mod_adder_pipe

Pipelined, parametrised modular adder computing (A + B) mod M, with M = 2^WIDTH − K, on a valid/ready stream. It is the sequential successor to the combinational hashed/enveloped/prefix modular adder datapath. It adds a runtime-loadable K register, configurable register insertion in the parallel-prefix tree, operand range checking, tag passthrough and backpressure. It sits between operand producers and the residue-arithmetic consumers in the modular datapath.

## Interface
Parameters:
- WIDTH, 7: operand/result width n; the modulus is M = 2^n − K.
- REG_EVERY, 1: number of prefix-tree levels between pipeline registers (≥1).
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- K_RESET, 20: value loaded into the K register at reset (reset M = 108 for n = 7).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  load cfg_k into the K register this cycle.
- cfg_k  in  WIDTH  new K; legal 1 … 2^n − 2.
- k_q  out  WIDTH  current K register value.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_sum  out  WIDTH  (A + B) mod M.
- out_err  out  1  1 if A ≥ M or B ≥ M at acceptance.
- out_tag  out  TAG_W  tag of this result.
- busy  out  1  any stage holds a valid beat.

## Operation
- Stage 1, registered on accept: per-bit g = a&b, h = a^b, p = a|b. Per-bit K-selected a′/b′ (k=1: a′ = XNOR(a,b), b′ = a|b; k=0: a′ = a^b, b′ = a&b). Enveloped g′/h′/p′ from a′_i and b′_{i−1}, with b′_{−1} = 0. The K register is sampled here only. Also registered: err = (A ≥ M) | (B ≥ M), tag, and valid.
- Prefix stages: two Sklansky-style parallel-prefix trees over (g,p) and (g′,p′), L = ceil(log2 n) levels. A pipeline register follows every REG_EVERY levels; the last partial group is also registered. Each tree cell computes p_out = p_i & p_j and g_out = g_i | (g_j & p_i).
- Final stage: c_out = G[n−1] and c_out′ = G′[n−1] plus b′_{n−1}. If c_out | c_out′, the sum is h′ ^ {G′ carries, 0}; otherwise it is h ^ {G carries, 0}. The result is registered in the output register.
- For A, B < M the result equals (A + B) mod M exactly. For err = 1, out_sum is the raw datapath output (don't-care) and is still delivered.
- Pipeline control uses a global enable: adv = !out_valid || out_ready, and in_ready = adv. When adv = 0 every stage holds. Bubbles are not collapsed.
- Configuration: cfg_we writes K at the clock edge. A beat accepted in the same cycle uses the old K. Beats accepted later use the new K. In-flight beats are unaffected.
- busy = OR of all stage valid bits.

## Timing
- Latency LAT = 2 + ceil(L / REG_EVERY) cycles from accept to out_valid. With no stall, this is 5 for n = 7 and REG_EVERY = 1.
- Throughput is one beat per cycle while out_ready = 1.
- A stall freezes all data and valid bits. out_sum, out_tag and out_err stay stable while out_valid && !out_ready.
- Reset: all valid bits 0, out_valid 0, out_sum 0, out_err 0, out_tag 0, busy 0, k_q = K_RESET, in_ready 1 on the first cycle after release. Assertion mid-operation discards all in-flight beats.
- Simultaneous output handshake and input accept in a full pipe: both take effect, with no bubble inserted.

## Test plan
- Reset K = 20, n = 7: A = 69, B = 45 -> out_sum = 6, out_err = 0, out_valid exactly 5 cycles after accept. Same check for A = 10, B = 20 -> 30, and A = 107, B = 107 -> 106.
- Back-to-back stream of 16 random in-range pairs with tags 0–15, out_ready held 1 -> results in order, tags match, one result per cycle.
- Random out_ready toggling (~50%) over 200 beats -> no loss, duplication or reorder. Outputs stable during stalls. in_ready == (!out_valid || out_ready) every cycle.
- cfg_we with cfg_k = 28 (M = 100) in the same cycle as accepting A = 60, B = 50 -> that result is 2 (old M = 108). The next beat, 60 + 50, -> 10. k_q = 28.
- A = 110, B = 3 with M = 108 -> out_err = 1 and the tag is preserved. A following in-range beat has err = 0.
- rst asserted for one cycle with 3 beats in flight -> out_valid and busy drop immediately, k_q = 20, no stale results after release.
